// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_pkg
//  Brief    : Shared real-time-clock timing constants and the helpers used to
//             derive the divide ratio and counter width from them.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_divider_pkg;

  // System clock feeding the RTC controller, in Hz.
  localparam int unsigned RTC_CLOCK_SPEED_HZ = 50_000_000;

  // Period of the RTC resolution tick, in ns.
  localparam int unsigned RTC_RESOLUTION_NS  = 100;

  // Nanoseconds per second; the product hz * ns must be a multiple of this.
  localparam longint unsigned NS_PER_S = 64'd1_000_000_000;

  // Counter width able to hold 0 .. div-1, never narrower than one bit.
  function automatic int unsigned rtc_cnt_width(input longint unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : clock_divider_pkg
`default_nettype wire

// File: rtl/clock_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_if
//  Brief    : Carries the divided RTC timebase from the divider to its
//             consumers (time-stamp counter, RTC controller).
//  Revision : 1.0 - initial release
// ============================================================================
interface clock_divider_if;

  // Divided, registered timebase clock.
  logic clock_div;

  // Producer side: the divider drives the timebase.
  modport master (output clock_div);

  // Consumer side: the time-stamp counter observes it.
  modport slave  (input  clock_div);

endinterface : clock_divider_if
`default_nettype wire

// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider
//  Brief    : Divides the system clock by DIV = hz * res_ns / 1e9 and drives a
//             registered, free-running divided clock. High for floor(DIV/2)
//             cycles, low for the rest of each period.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_HZ = RTC_CLOCK_SPEED_HZ,
  parameter int unsigned RTC_RESOLUTION = RTC_RESOLUTION_NS
) (
  input  logic clock,
  input  logic reset,
  output logic clock_div
);

  // Product done in 64 bits: 50e6 * 100 already overflows 32 bits.
  localparam longint unsigned PRODUCT = 64'(CLOCK_SPEED_HZ) * 64'(RTC_RESOLUTION);
  localparam longint unsigned DIV_L   = PRODUCT / NS_PER_S;
  localparam int unsigned     DIV     = 32'(DIV_L);
  localparam int unsigned     HIGH    = DIV / 2;
  localparam int unsigned     CW      = rtc_cnt_width(DIV_L);

  // Counter compare values, sized to the counter to keep widths exact.
  localparam logic [CW-1:0]   LAST_C  = CW'(DIV - 1);
  localparam logic [CW-1:0]   HIGH_C  = CW'(HIGH);

  // Reject ratios that are fractional or too small to toggle.
  if ((PRODUCT % NS_PER_S) != 64'd0) begin : g_bad_ratio
    $error("clock_divider: CLOCK_SPEED_HZ*RTC_RESOLUTION is not a multiple of 1e9");
  end
  if (DIV_L < 64'd2) begin : g_bad_div
    $error("clock_divider: divide ratio must be at least 2");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clock_div_q;
  logic          clock_div_d;

  // Next phase and next output level derived from the pre-edge phase.
  always_comb begin
    cnt_d       = cnt_q;
    clock_div_d = 1'b0;
    if (cnt_q == LAST_C) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    clock_div_d = (cnt_q < HIGH_C);
  end

  // Phase counter and output register; reset restarts the waveform.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      clock_div_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      clock_div_q <= clock_div_d;
    end
  end

  assign clock_div = clock_div_q;

endmodule : clock_divider
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider
//  Brief    : Bench for clock_divider at the default ratio (DIV=5) and at an
//             overridden ratio (100 MHz / 40 ns, DIV=4), driven from a shared
//             reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider;

  typedef struct {
    bit rst;
    bit e5;
    bit e4;
  } vec_t;

  typedef struct {
    string tag;
    bit    e5;
    bit    e4;
  } exp_t;

  logic clk;
  logic reset;

  clock_divider_if u_if5 ();
  clock_divider_if u_if4 ();

  clock_divider u_dut5 (
    .clock     (clk),
    .reset     (reset),
    .clock_div (u_if5.clock_div)
  );

  clock_divider #(
    .CLOCK_SPEED_HZ (100_000_000),
    .RTC_RESOLUTION (40)
  ) u_dut4 (
    .clock     (clk),
    .reset     (reset),
    .clock_div (u_if4.clock_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input bit got, input bit exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // Append a run of rows sharing one reset value; patterns are '0'/'1' strings.
  task automatic add_run(input bit r, input string p5, input string p4);
    for (int i = 0; i < p5.len(); i++) begin
      vecs.push_back('{rst: r, e5: (p5[i] == 8'h31), e4: (p4[i] == 8'h31)});
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input bit r, input bit e5, input bit e4, input string tag,
                      output bit got5, output bit got4);
    exp_t item;
    @(negedge clk);
    reset = r;
    sb.push_back('{tag: tag, e5: e5, e4: e4});
    @(posedge clk);
    #1;
    got5 = u_if5.clock_div;
    got4 = u_if4.clock_div;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected one entry", tag);
    end else begin
      item = sb.pop_front();
      check({item.tag, "/div5"}, got5, item.e5);
      check({item.tag, "/div4"}, got4, item.e4);
    end
  endtask

  initial begin
    bit g5, g4, p5, p4;
    int rises5, rises4, hi5, lo5, hi4, lo4;
    bit seen5, seen4;

    reset = 1'b1;

    // Reset, release, mid-high reset pulse, held reset, mid-low reset.
    add_run(1'b1, "000",         "000");
    add_run(1'b0, "11000110001", "11001100110");
    add_run(1'b1, "0",           "0");
    add_run(1'b0, "1100011",     "1100110");
    add_run(1'b1, "000",         "000");
    add_run(1'b0, "110",         "110");
    add_run(1'b1, "0",           "0");
    add_run(1'b0, "11000",       "11001");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].e5, vecs[i].e4, $sformatf("vec%0d", i), g5, g4);
    end

    // Long run: one reset cycle, then 1000 free-running cycles.
    step(1'b1, 1'b0, 1'b0, "long_reset", g5, g4);
    p5 = 1'b0; p4 = 1'b0;
    rises5 = 0; rises4 = 0;
    hi5 = 0; lo5 = 0; hi4 = 0; lo4 = 0;
    seen5 = 1'b0; seen4 = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      step(1'b0, ((k - 1) % 5) < 2, ((k - 1) % 4) < 2, $sformatf("long%0d", k), g5, g4);

      if (g5 && !p5) begin
        rises5++;
        if (seen5) check($sformatf("low_len5@%0d", k), lo5 == 3, 1'b1);
        seen5 = 1'b1; hi5 = 1;
      end else if (g5) begin
        hi5++;
      end else if (p5) begin
        check($sformatf("high_len5@%0d", k), hi5 == 2, 1'b1);
        lo5 = 1;
      end else begin
        lo5++;
      end

      if (g4 && !p4) begin
        rises4++;
        if (seen4) check($sformatf("low_len4@%0d", k), lo4 == 2, 1'b1);
        seen4 = 1'b1; hi4 = 1;
      end else if (g4) begin
        hi4++;
      end else if (p4) begin
        check($sformatf("high_len4@%0d", k), hi4 == 2, 1'b1);
        lo4 = 1;
      end else begin
        lo4++;
      end

      p5 = g5;
      p4 = g4;
    end

    checks++;
    if (rises5 != 200) begin
      errors++;
      $display("FAIL rises5: got %0d expected 200", rises5);
    end
    checks++;
    if (rises4 != 250) begin
      errors++;
      $display("FAIL rises4: got %0d expected 250", rises4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_clock_divider
`default_nettype wire
